// File: rtl/stream_mux_nt1_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_nt1_pkg
// Shared constants for the N-to-1 stream multiplexer:
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   sel_width(n)         : width of a channel index for n channels (min 1 bit)
// -----------------------------------------------------------------------------
package stream_mux_nt1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Equivalent to $clog2(n) for n >= 2, but never returns 0 so that a
    // degenerate configuration still yields a legal vector width.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_mux_nt1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant search with a rotating priority pointer.
//   clk, rst  : clock, asynchronous active-high reset (ptr -> 0)
//   req       : per-channel request (in_valid)
//   advance   : a transfer happened on the granted channel this cycle
//   enable    : pointer may move (round-robin mode active)
//   gnt_idx   : first requesting channel at or after ptr, modulo N
//   gnt_valid : at least one channel is requesting
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_nt1_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    input  logic             enable,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int             NP    = 1 << SEL_W;
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [NP-1:0]    req_pad;
    logic [SEL_W:0]   idx;

    // Pad to a power of two so any index value addresses a real bit.
    assign req_pad = NP'(req);

    // Walk offsets from the far end back to 0: the last hit written is the
    // one nearest to ptr, which gives the round-robin priority without a
    // separate "found" flag.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            if (req_pad[idx[SEL_W-1:0]]) begin
                gnt_idx   = idx[SEL_W-1:0];
                gnt_valid = 1'b1;
            end
        end
    end

    // The winner drops to lowest priority; with no transfer the pointer holds.
    always_comb begin
        ptr_d = ptr_q;
        if (enable && advance && gnt_valid) begin
            ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_nt1.sv
// -----------------------------------------------------------------------------
// stream_mux_nt1
// N-to-1 valid/ready multiplexer with a single registered output stage.
//   clk, rst  : clock, asynchronous active-high reset
//   mode      : MODE_FIXED (use sel) or MODE_RR (round-robin among valids)
//   sel       : channel index used in fixed mode
//   in_data   : channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, at most one bit high (combinational)
//   out_data  : registered selected word
//   out_src   : registered index of the channel that supplied out_data
//   out_valid : registered output valid
//   out_ready : consumer ready
// -----------------------------------------------------------------------------
module stream_mux_nt1
    import stream_mux_nt1_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;

    logic             load_en;
    logic             transfer;
    logic             sel_in_range;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic [WIDTH-1:0] grant_data;

    // Output register is free, or is being emptied this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Only a non-power-of-two N can present an index with no channel behind it.
    generate
        if ((1 << SEL_W) == N) begin : g_sel_full
            assign sel_in_range = 1'b1;
        end else begin : g_sel_part
            assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(N));
        end
    endgenerate

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (transfer),
        .enable    (mode == MODE_RR),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    always_comb begin
        grant    = sel;
        grant_ok = sel_in_range;
        if (mode == MODE_RR) begin
            grant    = rr_idx;
            grant_ok = rr_valid;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready[gi] = load_en && grant_ok && (grant == SEL_W'(gi));
        end
    endgenerate

    assign transfer = |(in_valid & in_ready);

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A new word wins over draining, so drain+load keeps out_valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_src_d   = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_nt1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_nt1
// Directed bench for stream_mux_nt1 (WIDTH=64, N=4) plus an N=3 instance for
// the out-of-range select case. Accepted words are queued as they are driven
// and compared against the registered output.
// -----------------------------------------------------------------------------
module tb_stream_mux_nt1;
    import stream_mux_nt1_pkg::*;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  s;
    } item_t;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [255:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [63:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    logic         mode3;
    logic [1:0]   sel3;
    logic [191:0] in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [63:0]  out_data3;
    logic [1:0]   out_src3;
    logic         out_valid3;
    logic         out_ready3;

    int    checks   = 0;
    int    failures = 0;
    item_t sb[$];
    int    m_ptr    = 0;
    int    last_grant;
    int    rr_seq[5] = '{0, 1, 2, 3, 0};

    stream_mux_nt1 #(.WIDTH(64), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_nt1 #(.WIDTH(64), .N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Called at posedge+1 after the inputs are driven; returns at the next posedge+1.
    task automatic step(input string tag);
        logic       load_en;
        logic [3:0] exp_rdy;
        logic       xfer;
        int         g;
        #1;
        load_en = (sb.size() == 0) || out_ready;
        if (mode == MODE_FIXED) g = int'(sel);
        else                    g = rr_pick(in_valid, m_ptr);
        exp_rdy = (g >= 0 && load_en) ? (4'b0001 << g) : 4'b0000;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
        xfer = |(exp_rdy & in_valid);
        @(posedge clk);
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (xfer) begin
            sb.push_back('{d: in_data[g*64 +: 64], s: 2'(g)});
            if (mode == MODE_RR) m_ptr = (g + 1) % 4;
        end
        last_grant = g;
        #1;
        chk({tag, " out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({tag, " out_data"}, out_data, sb[0].d);
            chk({tag, " out_src"}, 64'(out_src), 64'(sb[0].s));
        end
        $display("step %s: in_valid=%b in_ready=%b out_valid=%b out_src=%0d out_data=%h",
                 tag, in_valid, in_ready, out_valid, out_src, out_data);
    endtask

    initial begin
        rst        = 1'b1;
        mode       = MODE_FIXED;
        sel        = 2'd0;
        in_valid   = 4'b0000;
        out_ready  = 1'b1;
        mode3      = MODE_FIXED;
        sel3       = 2'd0;
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
        for (int c = 0; c < 4; c++) in_data[c*64 +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(c);
        for (int c = 0; c < 3; c++) in_data3[c*64 +: 64] = 64'hCAFE_0000_0000_0000 | 64'(c);

        // Reset state and idle readiness (in_ready independent of in_valid in fixed mode).
        #12;
        rst = 1'b0;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset out_src", 64'(out_src), 64'd0);
        chk("idle in_ready", 64'(in_ready), 64'(4'b0001));
        @(posedge clk);
        #1;

        // Fixed select of channel 2 with every channel valid.
        sel      = 2'd2;
        in_valid = 4'b1111;
        step("fixed sel2");
        chk("fixed src", 64'(out_src), 64'd2);
        chk("fixed data", out_data, 64'hDEAD_BEEF_0000_0002);
        in_valid = 4'b0000;
        step("fixed drain");

        // Round-robin fairness, one word per cycle (ptr untouched by fixed mode).
        mode     = MODE_RR;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step("rr all");
            chk("rr sequence", 64'(out_src), 64'(rr_seq[i]));
        end
        // Move ptr to 3, then skip idle channels with wrap.
        step("rr to ptr2");
        step("rr to ptr3");
        in_valid = 4'b0101;
        step("rr wrap");
        chk("rr wrap src", 64'(out_src), 64'd0);
        step("rr skip");
        chk("rr skip src", 64'(out_src), 64'd2);

        // Backpressure: the held word survives new inputs and a mode change.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        step("bp 1");
        mode = MODE_FIXED;
        step("bp 2");
        mode = MODE_RR;
        step("bp 3");
        chk("bp held src", 64'(out_src), 64'd2);
        out_ready = 1'b1;
        step("drain+load");
        chk("drain+load src", 64'(out_src), 64'd3);
        step("rr after bp");
        chk("rr after bp src", 64'(out_src), 64'd0);

        // Asynchronous reset while a word is held; ptr (now 1) returns to 0.
        #3;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst out_data", out_data, 64'd0);
        chk("async rst out_src", 64'(out_src), 64'd0);
        sb.delete();
        m_ptr    = 0;
        mode     = MODE_FIXED;
        sel      = 2'd0;
        in_valid = 4'b0000;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post rst in_ready", 64'(in_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        mode     = MODE_RR;
        in_valid = 4'b1111;
        step("rr after rst");
        chk("rr after rst src", 64'(out_src), 64'd0);
        in_valid = 4'b0000;
        step("final drain");

        // N=3 instance: an index past the last channel accepts nothing.
        in_valid3 = 3'b111;
        #1;
        chk("n3 sel0 in_ready", 64'(in_ready3), 64'(3'b001));
        @(posedge clk);
        #1;
        chk("n3 load out_valid", 64'(out_valid3), 64'd1);
        chk("n3 load out_data", out_data3, 64'hCAFE_0000_0000_0000);
        sel3 = 2'd3;
        #1;
        chk("n3 sel3 in_ready", 64'(in_ready3), 64'(3'b000));
        @(posedge clk);
        #1;
        chk("n3 sel3 drained", 64'(out_valid3), 64'd0);
        @(posedge clk);
        #1;
        chk("n3 sel3 stays empty", 64'(out_valid3), 64'd0);
        $display("n3: sel=3 in_ready=%b out_valid=%b", in_ready3, out_valid3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
